rr_arbiter_idx: RTL and testbench

- Round-robin arbiter that sits directly upstream of the decoder.
- Takes a request vector and produces a registered binary grant index with a valid/ready handshake.
- Index and valid drive the decoder's a_i/a_valid_i to form the one-hot grant.
- Guarantees fairness across NUM_REQ requesters, including non-power-of-2 counts.

---
 rtl/rr_arbiter_idx_if.sv | 26 ++
 rtl/rr_arbiter_idx.sv | 101 ++++++++++
 tb/tb_rr_arbiter_idx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_idx_if.sv
// Request/grant bundle between the round-robin arbiter and its downstream decoder.
// The master side is the arbiter; the slave side is the consumer of the grant index.
interface rr_arbiter_idx_if #(
  parameter int NUM_REQ = 5
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_i;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic               gnt_valid_o;
  logic               gnt_ready_i;

  modport master (
    input  req_i,
    input  gnt_ready_i,
    output gnt_idx_o,
    output gnt_valid_o
  );

  modport slave (
    output req_i,
    output gnt_ready_i,
    input  gnt_idx_o,
    input  gnt_valid_o
  );
endinterface

// File: rtl/rr_arbiter_idx.sv
// Round-robin arbiter producing a registered binary grant index with valid/ready.
// Fair across any NUM_REQ >= 2; the priority pointer moves past each accepted grant.
module rr_arbiter_idx #(
  parameter int NUM_REQ = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  rr_arbiter_idx_if.master  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] next_ptr;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(NUM_REQ - 1)) begin
      wrap_inc = '0;
    end else begin
      wrap_inc = p + IDX_W'(1);
    end
  endfunction

  // Cyclic scan starting at p; the first set bit encountered wins.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] kk;
    logic             found;
    int               k;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(p) + i;
      if (k >= NUM_REQ) begin
        k = k - NUM_REQ;
      end
      kk = IDX_W'(k);
      if (!found && req[kk]) begin
        res   = kk;
        found = 1'b1;
      end
    end
    pick = res;
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    next_ptr    = wrap_inc(gnt_idx_q);
    case (state_q)
      IDLE: begin
        gnt_valid_d = 1'b0;
        if (|bus.req_i) begin
          gnt_idx_d   = pick(bus.req_i, ptr_q);
          gnt_valid_d = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Without a handshake the grant is frozen regardless of req_i.
        if (bus.gnt_ready_i) begin
          ptr_d = next_ptr;
          if (|bus.req_i) begin
            gnt_idx_d = pick(bus.req_i, next_ptr);
          end else begin
            gnt_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign bus.gnt_idx_o   = gnt_idx_q;
  assign bus.gnt_valid_o = gnt_valid_q;
endmodule

// File: tb/tb_rr_arbiter_idx.sv
// Directed and random checks of rr_arbiter_idx with a 5-requester configuration.
// Each driven cycle queues its expected grant, which is popped once the edge has passed.
module tb_rr_arbiter_idx;
  localparam int NUM_REQ = 5;

  typedef struct {
    string      tag;
    logic       v;
    logic [2:0] idx;
    bit         idx_care;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  logic       m_valid;
  logic [2:0] m_idx;
  logic [2:0] m_ptr;

  rr_arbiter_idx_if #(.NUM_REQ(NUM_REQ)) bus ();

  rr_arbiter_idx #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference pick: modular scan from p.
  function automatic logic [2:0] model_pick(input logic [4:0] r, input logic [2:0] p);
    for (int s = 0; s < NUM_REQ; s++) begin
      if (r[(int'(p) + s) % NUM_REQ]) return 3'((int'(p) + s) % NUM_REQ);
    end
    return 3'd0;
  endfunction

  task automatic checkOutput();
    exp_t       e;
    logic [4:0] dec_dut;
    logic [4:0] dec_exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert ((bus.gnt_valid_o === e.v) && (!e.idx_care || (bus.gnt_idx_o === e.idx)))
    else begin
      errors++;
      $error("[TB] FAIL %s observed valid=%b idx=%0d expected valid=%b idx=%0d",
             e.tag, bus.gnt_valid_o, bus.gnt_idx_o, e.v, e.idx);
    end
    checks++;
    assert (!(bus.gnt_valid_o === 1'b1) || (bus.gnt_idx_o < 3'd5))
    else begin
      errors++;
      $error("[TB] FAIL %s_range observed idx=%0d expected idx<5", e.tag, bus.gnt_idx_o);
    end
    dec_dut = (bus.gnt_valid_o === 1'b1) ? (5'b00001 << bus.gnt_idx_o) : 5'b00000;
    dec_exp = e.v ? (5'b00001 << e.idx) : 5'b00000;
    checks++;
    assert (dec_dut === dec_exp)
    else begin
      errors++;
      $error("[TB] FAIL %s_onehot observed=%b expected=%b", e.tag, dec_dut, dec_exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic r_rst, input logic [4:0] r_req,
                               input logic r_rdy, input logic ev, input logic [2:0] ei,
                               input bit care);
    exp_t e;
    rst             = r_rst;
    bus.req_i       = r_req;
    bus.gnt_ready_i = r_rdy;
    e.tag      = tag;
    e.v        = ev;
    e.idx      = ei;
    e.idx_care = care;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [4:0] r;
    logic       rd;
    logic [2:0] nxt;
    checks = 0;
    errors = 0;
    rst             = 1'b1;
    bus.req_i       = 5'b11111;
    bus.gnt_ready_i = 1'b0;

    applyStimulus("reset_a",    1'b1, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1);
    applyStimulus("reset_b",    1'b1, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b1);
    applyStimulus("first_gnt",  1'b0, 5'b11111, 1'b1, 1'b1, 3'd0, 1'b1);

    applyStimulus("rot_1",      1'b0, 5'b11111, 1'b1, 1'b1, 3'd1, 1'b1);
    applyStimulus("rot_2",      1'b0, 5'b11111, 1'b1, 1'b1, 3'd2, 1'b1);
    applyStimulus("rot_3",      1'b0, 5'b11111, 1'b1, 1'b1, 3'd3, 1'b1);
    applyStimulus("rot_4",      1'b0, 5'b11111, 1'b1, 1'b1, 3'd4, 1'b1);
    applyStimulus("rot_0",      1'b0, 5'b11111, 1'b1, 1'b1, 3'd0, 1'b1);
    applyStimulus("rot_1b",     1'b0, 5'b11111, 1'b1, 1'b1, 3'd1, 1'b1);

    applyStimulus("bp_gnt2",    1'b0, 5'b11111, 1'b1, 1'b1, 3'd2, 1'b1);
    applyStimulus("bp_hold_a",  1'b0, 5'b00100, 1'b0, 1'b1, 3'd2, 1'b1);
    applyStimulus("bp_hold_b",  1'b0, 5'b11011, 1'b0, 1'b1, 3'd2, 1'b1);
    applyStimulus("bp_hold_c",  1'b0, 5'b00100, 1'b0, 1'b1, 3'd2, 1'b1);
    applyStimulus("bp_hold_d",  1'b0, 5'b11011, 1'b0, 1'b1, 3'd2, 1'b1);
    applyStimulus("bp_release", 1'b0, 5'b11011, 1'b1, 1'b1, 3'd3, 1'b1);

    applyStimulus("skip_to_1",  1'b0, 5'b00010, 1'b1, 1'b1, 3'd1, 1'b1);
    applyStimulus("skip_to_4",  1'b0, 5'b10000, 1'b1, 1'b1, 3'd4, 1'b1);
    applyStimulus("wrap_to_0",  1'b0, 5'b00001, 1'b1, 1'b1, 3'd0, 1'b1);

    applyStimulus("drain_g3",   1'b0, 5'b01000, 1'b1, 1'b1, 3'd3, 1'b1);
    applyStimulus("drain_idle", 1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0);
    applyStimulus("idle_quiet", 1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0);
    applyStimulus("idle_req3",  1'b0, 5'b01000, 1'b0, 1'b1, 3'd3, 1'b1);
    applyStimulus("drain_2",    1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0);
    applyStimulus("idle_rdy",   1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0);
    applyStimulus("idle_ptr4",  1'b0, 5'b11111, 1'b0, 1'b1, 3'd4, 1'b1);

    applyStimulus("mid_gnt2",   1'b0, 5'b00100, 1'b1, 1'b1, 3'd2, 1'b1);
    applyStimulus("mid_hold",   1'b0, 5'b00100, 1'b0, 1'b1, 3'd2, 1'b1);
    applyStimulus("mid_reset",  1'b1, 5'b11111, 1'b1, 1'b0, 3'd0, 1'b1);
    applyStimulus("post_reset", 1'b0, 5'b11111, 1'b0, 1'b1, 3'd0, 1'b1);

    applyStimulus("single_a",   1'b0, 5'b00100, 1'b1, 1'b1, 3'd2, 1'b1);
    applyStimulus("single_b",   1'b0, 5'b00100, 1'b1, 1'b1, 3'd2, 1'b1);

    m_valid = 1'b1;
    m_idx   = 3'd2;
    m_ptr   = 3'd3;
    for (int n = 0; n < 1000; n++) begin
      r  = 5'($urandom_range(0, 31));
      rd = 1'($urandom_range(0, 1));
      if (!m_valid) begin
        if (|r) begin
          m_idx   = model_pick(r, m_ptr);
          m_valid = 1'b1;
        end
      end else if (rd) begin
        nxt   = 3'((int'(m_idx) + 1) % NUM_REQ);
        m_ptr = nxt;
        if (|r) begin
          m_idx = model_pick(r, nxt);
        end else begin
          m_valid = 1'b0;
        end
      end
      applyStimulus("random", 1'b0, r, rd, m_valid, m_idx, m_valid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
